// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
package bcd_pkg;

  localparam int NIBBLE      = 4;
  localparam int DIGITOS_INT = 5;
  localparam int MAX_BCD     = 9999;
  localparam int ANCHO_BCD   = DIGITOS_INT * NIBBLE;

  typedef enum logic [1:0] {
    IDLE,
    DESPLAZA,
    FIN
  } estado_t;

  // Double-dabble correction: any digit that would reach 10 after the shift is pre-biased by 3.
  function automatic logic [NIBBLE-1:0] suma_tres(input logic [NIBBLE-1:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/ajuste_bcd.sv
// Combinational add-3 correction for one BCD nibble.
module ajuste_bcd
  import bcd_pkg::*;
(
  input  logic [NIBBLE-1:0] nibble,
  output logic [NIBBLE-1:0] resultado
);

  assign resultado = suma_tres(nibble);

endmodule

// File: rtl/convertidor_bin_bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per cycle.
// Optional macro BCD_SATURACION_EN: clamp results above 9999 to 9999 and flag overflow.
module convertidor_bin_bcd
  import bcd_pkg::*;
#(
  parameter int ANCHO = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ANCHO-1:0] binario,
  input  logic             start,
  output logic [3:0]       unidades,
  output logic [3:0]       decenas,
  output logic [3:0]       centenas,
  output logic [3:0]       unidadesMillar,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  localparam int W  = ANCHO_BCD + ANCHO;
  localparam int CW = $clog2(ANCHO + 1);

  estado_t           estado_reg, estado_next;
  logic [W-1:0]      trabajo_reg;
  logic [W-1:0]      trabajo_ajustado;
  logic [CW-1:0]     cuenta_reg;
  logic              ultima;
  logic [ANCHO_BCD-1:0] bcd_ajustado;
  logic [3:0]        unidades_reg, decenas_reg, centenas_reg, millar_reg;
  logic              done_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITOS_INT; gi++) begin : g_ajuste
      ajuste_bcd u_ajuste (
        .nibble    (trabajo_reg[ANCHO + NIBBLE*gi +: NIBBLE]),
        .resultado (bcd_ajustado[NIBBLE*gi +: NIBBLE])
      );
    end
  endgenerate

  assign trabajo_ajustado = {bcd_ajustado, trabajo_reg[ANCHO-1:0]};
  assign ultima           = (cuenta_reg == CW'(ANCHO - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) estado_reg <= IDLE;
    else     estado_reg <= estado_next;
  end

  always_comb begin
    estado_next = estado_reg;
    case (estado_reg)
      IDLE:     if (start) estado_next = DESPLAZA;
      DESPLAZA: if (ultima) estado_next = FIN;
      FIN:      estado_next = IDLE;
      default:  estado_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trabajo_reg <= '0;
      cuenta_reg  <= '0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= (estado_reg == FIN);
      case (estado_reg)
        IDLE: begin
          if (start) begin
            trabajo_reg <= {{ANCHO_BCD{1'b0}}, binario};
            cuenta_reg  <= '0;
          end
        end
        DESPLAZA: begin
          trabajo_reg <= trabajo_ajustado << 1;
          cuenta_reg  <= cuenta_reg + CW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef BCD_SATURACION_EN
  logic [3:0] decenas_millar;
  logic       overflow_reg;

  assign decenas_millar = trabajo_reg[ANCHO + 4*NIBBLE +: NIBBLE];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      unidades_reg <= '0;
      decenas_reg  <= '0;
      centenas_reg <= '0;
      millar_reg   <= '0;
      overflow_reg <= 1'b0;
    end else if (estado_reg == FIN) begin
      if (decenas_millar != 4'd0) begin
        unidades_reg <= 4'd9;
        decenas_reg  <= 4'd9;
        centenas_reg <= 4'd9;
        millar_reg   <= 4'd9;
        overflow_reg <= 1'b1;
      end else begin
        unidades_reg <= trabajo_reg[ANCHO +: NIBBLE];
        decenas_reg  <= trabajo_reg[ANCHO + NIBBLE +: NIBBLE];
        centenas_reg <= trabajo_reg[ANCHO + 2*NIBBLE +: NIBBLE];
        millar_reg   <= trabajo_reg[ANCHO + 3*NIBBLE +: NIBBLE];
        overflow_reg <= 1'b0;
      end
    end
  end

  assign overflow = overflow_reg;
`else
  // Ten-thousands digit is dropped; only the four displayed digits are kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      unidades_reg <= '0;
      decenas_reg  <= '0;
      centenas_reg <= '0;
      millar_reg   <= '0;
    end else if (estado_reg == FIN) begin
      unidades_reg <= trabajo_reg[ANCHO +: NIBBLE];
      decenas_reg  <= trabajo_reg[ANCHO + NIBBLE +: NIBBLE];
      centenas_reg <= trabajo_reg[ANCHO + 2*NIBBLE +: NIBBLE];
      millar_reg   <= trabajo_reg[ANCHO + 3*NIBBLE +: NIBBLE];
    end
  end

  assign overflow = 1'b0;
`endif

  assign unidades       = unidades_reg;
  assign decenas        = decenas_reg;
  assign centenas       = centenas_reg;
  assign unidadesMillar = millar_reg;
  assign busy           = (estado_reg != IDLE);
  assign done           = done_reg;

endmodule

// File: tb/tb_convertidor_bin_bcd.sv
// Directed self-checking bench for convertidor_bin_bcd at ANCHO=14.
module tb_convertidor_bin_bcd;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [13:0] binario = '0;
  logic        start = 1'b0;
  logic [3:0]  unidades, decenas, centenas, unidadesMillar;
  logic        busy, done, overflow;
  logic [15:0] dig;

  int checks = 0;
  int errors = 0;
  int lat, nbusy, ndone, cambios;

  always #5 clk = ~clk;

  convertidor_bin_bcd #(.ANCHO(14)) dut (
    .clk            (clk),
    .rst            (rst),
    .binario        (binario),
    .start          (start),
    .unidades       (unidades),
    .decenas        (decenas),
    .centenas       (centenas),
    .unidadesMillar (unidadesMillar),
    .busy           (busy),
    .done           (done),
    .overflow       (overflow)
  );

  assign dig = {unidadesMillar, centenas, decenas, unidades};

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Start one conversion and observe 20 cycles; optionally pulse start again at cycle pulso_n.
  task automatic convertir(input logic [13:0] v, input int pulso_n, input logic [13:0] pulso_v,
                           output int lat_o, output int nbusy_o, output int ndone_o, output int cambios_o);
    logic [15:0] ref_dig;
    lat_o = -1; nbusy_o = 0; ndone_o = 0; cambios_o = 0;
    ref_dig = dig;
    binario = v;
    start   = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (busy) nbusy_o++;
      if (done) begin
        ndone_o++;
        if (lat_o < 0) lat_o = n - 1;
      end
      if (lat_o < 0 && dig !== ref_dig) cambios_o++;
      if (n == pulso_n) begin
        start   = 1'b1;
        binario = pulso_v;
      end else begin
        start = 1'b0;
      end
    end
    $display("conv bin=%0d lat=%0d busy=%0d done=%0d digits=%h ovf=%0b", v, lat_o, nbusy_o, ndone_o, dig, overflow);
  endtask

  initial begin
    int primero, segundo, cuantos, ndone_rst;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_dig",  dig, 16'h0000);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf",  overflow, 0);
    rst = 1'b0;
    @(negedge clk);

    convertir(14'd0, 0, 14'd0, lat, nbusy, ndone, cambios);
    check("cero_lat",  lat, 15);
    check("cero_busy", nbusy, 15);
    check("cero_done", ndone, 1);
    check("cero_dig",  dig, 16'h0000);

    convertir(14'd1234, 0, 14'd0, lat, nbusy, ndone, cambios);
    check("d1234_dig",    dig, 16'h1234);
    check("d1234_done",   ndone, 1);
    check("d1234_stable", cambios, 0);
    check("d1234_lat",    lat, 15);

    convertir(14'd9999, 0, 14'd0, lat, nbusy, ndone, cambios);
    check("d9999_dig", dig, 16'h9999);
    check("d9999_ovf", overflow, 0);

    convertir(14'd5, 0, 14'd0, lat, nbusy, ndone, cambios);
    check("d5_dig", dig, 16'h0005);

    convertir(14'd12345, 0, 14'd0, lat, nbusy, ndone, cambios);
`ifdef BCD_SATURACION_EN
    check("d12345_dig", dig, 16'h9999);
    check("d12345_ovf", overflow, 1);
`else
    check("d12345_dig", dig, 16'h2345);
    check("d12345_ovf", overflow, 0);
`endif

    // Second start while busy must be ignored.
    convertir(14'd42, 5, 14'd777, lat, nbusy, ndone, cambios);
    check("ign_dig",  dig, 16'h0042);
    check("ign_done", ndone, 1);
    check("ign_busy", busy, 0);

    // Start held high: one result every ANCHO+2 cycles.
    primero = -1; segundo = -1; cuantos = 0;
    binario = 14'd777;
    start   = 1'b1;
    for (int n = 1; n <= 50; n++) begin
      @(negedge clk);
      if (done) begin
        cuantos++;
        if (primero < 0) primero = n;
        else if (segundo < 0) segundo = n;
      end
    end
    start = 1'b0;
    $display("held start first=%0d second=%0d count=%0d digits=%h", primero, segundo, cuantos, dig);
    check("held_period", segundo - primero, 16);
    check("held_count",  cuantos, 3);
    check("held_dig",    dig, 16'h0777);
    repeat (20) @(negedge clk);

    // Asynchronous reset mid-conversion.
    binario = 14'd1234;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_dig",  dig, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    ndone_rst = 0;
    for (int n = 1; n <= 25; n++) begin
      @(negedge clk);
      if (done) ndone_rst++;
    end
    $display("reset abort done_after=%0d digits=%h busy=%0b", ndone_rst, dig, busy);
    check("post_rst_done", ndone_rst, 0);
    check("post_rst_dig",  dig, 16'h0000);
    check("post_rst_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
